alarm_pattern_gen: RTL and testbench
====================================

ALARM_PATTERN_GEN -- requirements
Module: alarm_pattern_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per 1 ms tick.
REQ-002 SHALL have parameter ON_MS, default 200, beep-on duration in ms (legal range 1..65535).
REQ-003 SHALL have parameter OFF_MS, default 150, inter-beep gap in ms (legal range 1..65535).
REQ-004 SHALL have port clk  input  1  system clock, rising-edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  alarm request present.
REQ-007 SHALL have port req_count  input  3  beep count 1..7; 0 = continuous until cancel.
REQ-008 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-009 SHALL have port cancel  input  1  abort current and pending alarm.
REQ-010 SHALL have port play  output  1  registered enable driving the downstream tone player's play input.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE or a request is pending.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a counted pattern completes.

Function
REQ-013 SHALL accept a request on any rising clk edge where req_valid and req_ready are both high; req_count is sampled on that edge.
REQ-014 SHALL implement states IDLE, ON, GAP and DONE; play SHALL be high only in ON.
REQ-015 SHALL clear the ms prescaler and the ms counter on accept and on every state transition, so each ON phase lasts exactly ON_MS*TICK_DIV cycles and each GAP phase lasts exactly OFF_MS*TICK_DIV cycles.
REQ-016 SHALL go IDLE->ON on accept, with play high on the cycle after the accept edge; beeps_left SHALL be loaded with req_count.
REQ-017 SHALL, at the end of ON, decrement beeps_left in counted mode; if the result is 0 the next state is DONE, otherwise GAP.
REQ-018 SHALL go GAP->ON at the end of GAP.
REQ-019 SHALL, in continuous mode (count 0), alternate ON and GAP indefinitely with no decrement and never enter DONE.
REQ-020 SHALL hold DONE for exactly one cycle with done=1 and play=0, then go to IDLE (or as specified in REQ-027).
REQ-021 SHALL give cancel priority over every other event: any state goes to IDLE on the next edge, play=0, the pending request is cleared, and done is not pulsed.
REQ-022 SHALL hold req_ready low whenever cancel is high, so a simultaneous req_valid is not accepted.
REQ-023 SHALL make ms-counter widths sufficient for 65535 ms and the prescaler width sufficient for TICK_DIV-1, with no wrap-around within a phase.

Reset
REQ-024 SHALL, while rstn is low, force state=IDLE, play=0, done=0, busy=0, pending cleared, and all counters to 0, independent of clk.
REQ-025 SHALL, on rstn asserted mid-pattern, drop play within the reset assertion and resume in IDLE with req_ready=1 (cancel low) after reset release.

Configuration
REQ-026 SHALL, without ALARM_QUEUE_EN, drive req_ready = (state==IDLE) && !cancel.
REQ-027 SHALL, with ALARM_QUEUE_EN defined, add a one-entry pending buffer: req_ready = !pending_valid && !cancel; a request accepted in a non-IDLE state is stored; at DONE with pending valid, done still pulses and the next state is ON with the pending count loaded and the buffer cleared; a pending request behind a continuous pattern waits until cancel, which discards it.

Verification (TICK_DIV=4, ON_MS=3, OFF_MS=2)
REQ-028 SHALL cover: accept count=2 at edge 0 -> play high cycles 1-12, low 13-20, high 21-32; done=1 on cycle 33; IDLE and req_ready=1 on cycle 34.
REQ-029 SHALL cover: accept count=0, run 100 cycles -> 12-high/8-low play pattern repeats; done never asserted; cancel on cycle 50 -> play=0 and busy=0 from cycle 51.
REQ-030 SHALL cover: cancel and req_valid high in the same IDLE cycle -> req_ready=0, no accept, play stays 0.
REQ-031 SHALL cover: rstn pulled low at cycle 5 of an ON phase -> play=0 immediately (asynchronous); after release, state IDLE and all outputs at their reset values.
REQ-032 SHALL cover: with ALARM_QUEUE_EN, count=1 accepted, then count=1 offered at cycle 4 -> accepted (req_ready then 0); done pulses at cycle 13; play high again from cycle 14 to 25; second done at cycle 26.
REQ-033 SHALL cover: without ALARM_QUEUE_EN, req_valid held during an active pattern -> req_ready=0 until IDLE; the request is accepted on the first IDLE edge.

Source files
------------

// File: rtl/alarm_pattern_gen.sv
// Alarm beep sequencer: ON/GAP ms timing, counted or continuous patterns, cancel.
// Define ALARM_QUEUE_EN to add a one-entry pending request buffer.
module alarm_pattern_gen #(
  parameter int TICK_DIV = 100000,
  parameter int ON_MS    = 200,
  parameter int OFF_MS   = 150
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic [2:0] req_count,
  output logic       req_ready,
  input  logic       cancel,
  output logic       play,
  output logic       busy,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   ON_LAST    = 16'(ON_MS - 1);
  localparam logic [15:0]   OFF_LAST   = 16'(OFF_MS - 1);

  typedef enum logic [1:0] {IDLE, ON, GAP, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc;
  logic [15:0]     ms_cnt;
  logic [2:0]      beeps_left, beeps_nxt;
  logic            accept, tick, phase_end, active;
  logic            pend_valid;
  logic [2:0]      pend_count;

  assign accept    = req_valid && req_ready;
  assign active    = (state == ON) || (state == GAP);
  assign tick      = (presc == PRESC_LAST);
  assign phase_end = tick && (((state == ON)  && (ms_cnt == ON_LAST)) ||
                              ((state == GAP) && (ms_cnt == OFF_LAST)));
  assign busy      = (state != IDLE) || pend_valid;

`ifdef ALARM_QUEUE_EN
  assign req_ready = !pend_valid && !cancel;

  // A request arriving mid-pattern waits here; it is consumed at DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_valid <= 1'b0;
      pend_count <= 3'd0;
    end else if (cancel) begin
      pend_valid <= 1'b0;
    end else if (pend_valid && ((state == IDLE) || (state == DONE))) begin
      pend_valid <= 1'b0;
    end else if (accept && active) begin
      pend_valid <= 1'b1;
      pend_count <= req_count;
    end
  end
`else
  assign req_ready  = (state == IDLE) && !cancel;
  assign pend_valid = 1'b0;
  assign pend_count = 3'd0;
`endif

  // beeps_left == 0 while ON/GAP means continuous mode.
  always_comb begin
    state_nxt = state;
    beeps_nxt = beeps_left;
    if (cancel) begin
      state_nxt = IDLE;
      beeps_nxt = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_valid) begin
            state_nxt = ON;
            beeps_nxt = pend_count;
          end else if (accept) begin
            state_nxt = ON;
            beeps_nxt = req_count;
          end
        end
        ON: begin
          if (phase_end) begin
            if (beeps_left == 3'd0) begin
              state_nxt = GAP;
            end else begin
              beeps_nxt = beeps_left - 3'd1;
              state_nxt = (beeps_left == 3'd1) ? DONE : GAP;
            end
          end
        end
        GAP: begin
          if (phase_end) state_nxt = ON;
        end
        DONE: begin
          if (pend_valid) begin
            state_nxt = ON;
            beeps_nxt = pend_count;
          end else if (accept) begin
            state_nxt = ON;
            beeps_nxt = req_count;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      beeps_left <= 3'd0;
      play       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      beeps_left <= beeps_nxt;
      play       <= (state_nxt == ON);
      done       <= (state_nxt == DONE);
    end
  end

  // Timing restarts on every transition so each phase is exactly its length.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if ((state_nxt != state) || !active) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (tick) begin
      presc  <= '0;
      ms_cnt <= ms_cnt + 16'd1;
    end else begin
      presc  <= presc + 1'b1;
    end
  end

endmodule

// File: tb/tb_alarm_pattern_gen.sv
// Directed bench for alarm_pattern_gen (TICK_DIV=4, ON_MS=3, OFF_MS=2).
// Covers queued-request behaviour when ALARM_QUEUE_EN is defined.
module tb_alarm_pattern_gen;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_valid;
  logic [2:0] req_count;
  logic       req_ready;
  logic       cancel;
  logic       play;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       valid;
    logic [2:0] cnt;
    logic       cancel;
    int         n;
    logic       play;
    logic       done;
    logic       busy;
    logic       ready;
  } vec_t;

  vec_t tbl[$];

  alarm_pattern_gen #(.TICK_DIV(4), .ON_MS(3), .OFF_MS(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_count (req_count),
    .req_ready (req_ready),
    .cancel    (cancel),
    .play      (play),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic p, input logic d,
                         input logic b, input logic r);
    chk({nm, " play"},  play,      p);
    chk({nm, " done"},  done,      d);
    chk({nm, " busy"},  busy,      b);
    chk({nm, " ready"}, req_ready, r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [2:0] c, input logic cn, input int n,
                     input logic p, input logic d, input logic b, input logic r);
    vec_t e;
    e.valid = v; e.cnt = c; e.cancel = cn; e.n = n;
    e.play = p; e.done = d; e.busy = b; e.ready = r;
    tbl.push_back(e);
  endtask

  initial begin
    // Counted pattern, count=2: play 1-12, gap 13-20, play 21-32, done 33, idle 34.
    add(1, 3'd2, 0, 1,  1, 0, 1, 0);
    add(0, 3'd0, 0, 11, 1, 0, 1, 0);
    add(0, 3'd0, 0, 8,  0, 0, 1, 0);
    add(0, 3'd0, 0, 12, 1, 0, 1, 0);
    add(0, 3'd0, 0, 1,  0, 1, 1, 0);
    add(0, 3'd0, 0, 1,  0, 0, 0, 1);
    // Cancel together with a request in IDLE: nothing accepted.
    add(1, 3'd3, 1, 2,  0, 0, 0, 0);
    add(0, 3'd0, 0, 2,  0, 0, 0, 1);
    // Continuous pattern, cancel applied during cycle 50.
    add(1, 3'd0, 0, 1,  1, 0, 1, 0);
    add(0, 3'd0, 0, 11, 1, 0, 1, 0);
    add(0, 3'd0, 0, 8,  0, 0, 1, 0);
    add(0, 3'd0, 0, 12, 1, 0, 1, 0);
    add(0, 3'd0, 0, 8,  0, 0, 1, 0);
    add(0, 3'd0, 0, 9,  1, 0, 1, 0);
    add(0, 3'd0, 0, 1,  1, 0, 1, 0);
    add(0, 3'd0, 1, 1,  0, 0, 0, 0);
    add(0, 3'd0, 0, 2,  0, 0, 0, 1);
`ifdef ALARM_QUEUE_EN
    // Second count=1 request offered in cycle 4 is queued behind the first.
    add(1, 3'd1, 0, 1,  1, 0, 1, 1);
    add(0, 3'd0, 0, 3,  1, 0, 1, 1);
    add(1, 3'd1, 0, 1,  1, 0, 1, 0);
    add(0, 3'd0, 0, 7,  1, 0, 1, 0);
    add(0, 3'd0, 0, 1,  0, 1, 1, 0);
    add(0, 3'd0, 0, 12, 1, 0, 1, 1);
    add(0, 3'd0, 0, 1,  0, 1, 1, 1);
    add(0, 3'd0, 0, 1,  0, 0, 0, 1);
`else
    // Request held through a count=1 pattern: accepted on first IDLE edge.
    add(1, 3'd1, 0, 1,  1, 0, 1, 0);
    add(1, 3'd1, 0, 11, 1, 0, 1, 0);
    add(1, 3'd1, 0, 1,  0, 1, 1, 0);
    add(1, 3'd1, 0, 1,  0, 0, 0, 1);
    add(1, 3'd1, 0, 1,  1, 0, 1, 0);
    add(0, 3'd0, 1, 1,  0, 0, 0, 0);
    add(0, 3'd0, 0, 1,  0, 0, 0, 1);
`endif

    rstn = 1'b0; req_valid = 1'b0; req_count = 3'd0; cancel = 1'b0;
    #12;
    chk_all("reset", 0, 0, 0, 1);
    step();
    rstn = 1'b1;
    step();
    chk_all("post_reset", 0, 0, 0, 1);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        req_valid = tbl[r].valid;
        req_count = tbl[r].cnt;
        cancel    = tbl[r].cancel;
        step();
        chk_all($sformatf("rec%0d cyc%0d", r, k),
                tbl[r].play, tbl[r].done, tbl[r].busy, tbl[r].ready);
      end
    end
    req_valid = 1'b0; cancel = 1'b0;
    step();

    // Asynchronous reset in the 5th cycle of an ON phase.
    req_valid = 1'b1; req_count = 3'd3;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    chk("arst_pre play", play, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk_all("arst_async", 0, 0, 0, 1);
    step();
    step();
    chk_all("arst_held", 0, 0, 0, 1);
    rstn = 1'b1;
    step();
    chk_all("arst_release", 0, 0, 0, 1);
    step();
    chk_all("arst_idle", 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
